// File: rtl/dct_transpose.sv
// Double-banked 8x8 transpose buffer between the row-pass and column-pass 1-D DCT.
// Rows are written into one bank while the other bank is read out column by column.
module dct_transpose #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena_in,
  output logic         rdy_out,
  input  logic [W-1:0] d_in,
  output logic         ena_out,
  input  logic         rdy_in,
  output logic [W-1:0] d_out
);

  // Flat storage addressed as {bank, row, col}.
  logic [W-1:0] mem [128];

  logic       wr_sel;
  logic       wr_active;
  logic [2:0] wr_row;
  logic [2:0] wr_col;

  logic       rd_sel;
  logic       rd_active;
  logic [2:0] rd_row;
  logic [2:0] rd_col;

  logic [1:0] full;
  logic [1:0] full_set;
  logic [1:0] full_clr;
  logic       wr_start;
  logic       wr_last;
  logic       rd_last;

  assign rdy_out  = !rst && !full[wr_sel] && !wr_active;
  assign wr_start = ena_in && rdy_out;
  assign wr_last  = wr_active && (wr_col == 3'd7) && (wr_row == 3'd7);

  assign ena_out  = !rst && full[rd_sel] && !rd_active && rdy_in;
  assign rd_last  = rd_active && (rd_row == 3'd7) && (rd_col == 3'd7);

  // rd_row idles at 0, so element 0 is already addressed on the ena_out cycle.
  assign d_out = (!rst && (ena_out || rd_active)) ? mem[{rd_sel, rd_row, rd_col}] : '0;

  assign full_set = wr_last ? (2'b01 << wr_sel) : 2'b00;
  assign full_clr = rd_last ? (2'b01 << rd_sel) : 2'b00;

  always_ff @(posedge clk) begin
    if (wr_start || wr_active) begin
      mem[{wr_sel, wr_row, (wr_active ? wr_col : 3'd0)}] <= d_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_sel    <= 1'b0;
      wr_row    <= 3'd0;
      wr_col    <= 3'd0;
      wr_active <= 1'b0;
    end else if (wr_start) begin
      wr_active <= 1'b1;
      wr_col    <= 3'd1;
    end else if (wr_active) begin
      wr_col <= wr_col + 3'd1;
      if (wr_col == 3'd7) begin
        wr_active <= 1'b0;
        wr_row    <= wr_row + 3'd1;
        if (wr_row == 3'd7) begin
          wr_sel <= ~wr_sel;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_sel    <= 1'b0;
      rd_row    <= 3'd0;
      rd_col    <= 3'd0;
      rd_active <= 1'b0;
    end else if (ena_out) begin
      rd_active <= 1'b1;
      rd_row    <= 3'd1;
    end else if (rd_active) begin
      rd_row <= rd_row + 3'd1;
      if (rd_row == 3'd7) begin
        rd_active <= 1'b0;
        rd_col    <= rd_col + 3'd1;
        if (rd_col == 3'd7) begin
          rd_sel <= ~rd_sel;
        end
      end
    end
  end

  // Set and clear always hit different banks, so both can apply in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 2'b00;
    end else begin
      full <= (full | full_set) & ~full_clr;
    end
  end

endmodule

// File: tb/tb_dct_transpose.sv
// Self-checking bench for dct_transpose: a protocol model fills a scoreboard of
// transposed blocks and every cycle's handshake and data outputs are compared.
module tb_dct_transpose;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst;
  logic         ena_in;
  logic         rdy_out;
  logic [W-1:0] d_in;
  logic         ena_out;
  logic         rdy_in;
  logic [W-1:0] d_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int row_start_cycle;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] blk [8][8];
  bit m_in_active;
  int m_in_row, m_in_col;
  bit m_out_active;
  int m_out_pos, m_out_col;
  int m_nfull;

  typedef struct {
    bit rst;
    bit rdy_in;
    bit exp_rdy;
    bit exp_ena;
  } vec_t;
  vec_t tbl[6];

  dct_transpose #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena_in  (ena_in),
    .rdy_out (rdy_out),
    .d_in    (d_in),
    .ena_out (ena_out),
    .rdy_in  (rdy_in),
    .d_out   (d_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model of both burst protocols; predictions come from model state only.
  always @(negedge clk) begin
    bit p_rdy, p_ena;
    int inc, dec;
    inc = 0;
    dec = 0;
    if (rst) begin
      checkOutput("rst_rdy_out", int'(rdy_out), 0);
      checkOutput("rst_ena_out", int'(ena_out), 0);
      checkOutput("rst_d_out", int'(d_out), 0);
      exp_q.delete();
      m_in_active = 0; m_in_row = 0; m_in_col = 0;
      m_out_active = 0; m_out_pos = 0; m_out_col = 0;
      m_nfull = 0;
    end else begin
      p_rdy = !m_in_active && (m_nfull < 2);
      p_ena = (m_nfull > 0) && !m_out_active && rdy_in;
      checkOutput("rdy_out", int'(rdy_out), int'(p_rdy));
      checkOutput("ena_out", int'(ena_out), int'(p_ena));
      if (p_ena || m_out_active) begin
        if (exp_q.size() == 0) begin
          checkOutput("d_out_underflow", 1, 0);
        end else begin
          checkOutput("d_out", int'(d_out), int'(exp_q.pop_front()));
        end
        if (p_ena) begin
          m_out_active = 1;
          m_out_pos = 0;
        end
        m_out_pos++;
        if (m_out_pos == 8) begin
          m_out_active = 0;
          m_out_col++;
          if (m_out_col == 8) begin
            m_out_col = 0;
            dec = 1;
          end
        end
      end else begin
        checkOutput("d_out_idle", int'(d_out), 0);
      end
      if ((ena_in && p_rdy) || m_in_active) begin
        if (!m_in_active) begin
          m_in_active = 1;
          m_in_col = 0;
        end
        blk[m_in_row][m_in_col] = d_in;
        m_in_col++;
        if (m_in_col == 8) begin
          m_in_active = 0;
          m_in_row++;
          if (m_in_row == 8) begin
            m_in_row = 0;
            for (int c = 0; c < 8; c++)
              for (int r = 0; r < 8; r++)
                exp_q.push_back(blk[r][c]);
            inc = 1;
          end
        end
      end
      m_nfull = m_nfull + inc - dec;
    end
  end

  // Waits (bounded) for rdy_out, then drives one 8-element row burst.
  task automatic applyStimulus(input logic [8*W-1:0] row);
    int waited;
    waited = 0;
    while (!rdy_out && waited < 300) begin
      step();
      waited++;
    end
    if (!rdy_out) checkOutput("rdy_out_timeout", 0, 1);
    row_start_cycle = cycle;
    ena_in = 1'b1;
    d_in = row[W-1:0];
    step();
    ena_in = 1'b0;
    for (int k = 1; k < 8; k++) begin
      d_in = row[k*W +: W];
      step();
    end
  endtask

  task automatic send_block(input int offset, input bit extremes);
    logic [8*W-1:0] row;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        if (extremes) row[c*W +: W] = ((r + c) % 2 == 1) ? 12'h7FF : 12'h800;
        else          row[c*W +: W] = W'(offset + 8*r + c);
      end
      applyStimulus(row);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_out_active || m_nfull != 0) && n < 2000) begin
      step();
      n++;
    end
    checkOutput("drain_done", int'(exp_q.size() == 0 && m_nfull == 0), 1);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int first_start;
    logic [8*W-1:0] row;
    tbl[0] = '{rst: 1'b1, rdy_in: 1'b1, exp_rdy: 1'b0, exp_ena: 1'b0};
    tbl[1] = '{rst: 1'b1, rdy_in: 1'b0, exp_rdy: 1'b0, exp_ena: 1'b0};
    tbl[2] = '{rst: 1'b0, rdy_in: 1'b1, exp_rdy: 1'b1, exp_ena: 1'b0};
    tbl[3] = '{rst: 1'b0, rdy_in: 1'b0, exp_rdy: 1'b1, exp_ena: 1'b0};
    tbl[4] = '{rst: 1'b1, rdy_in: 1'b1, exp_rdy: 1'b0, exp_ena: 1'b0};
    tbl[5] = '{rst: 1'b0, rdy_in: 1'b1, exp_rdy: 1'b1, exp_ena: 1'b0};

    rst = 1'b1; ena_in = 1'b0; rdy_in = 1'b0; d_in = '0;
    repeat (3) step();

    for (int i = 0; i < 6; i++) begin
      rst = tbl[i].rst;
      rdy_in = tbl[i].rdy_in;
      #1;
      checkOutput("tbl_rdy_out", int'(rdy_out), int'(tbl[i].exp_rdy));
      checkOutput("tbl_ena_out", int'(ena_out), int'(tbl[i].exp_ena));
      checkOutput("tbl_d_out", int'(d_out), 0);
      step();
    end

    $display("[TB] single block, first-output latency");
    rdy_in = 1'b1;
    send_block(0, 1'b0);
    checkOutput("first_ena_latency", int'(ena_out), 1);
    checkOutput("col0_elem0", int'(d_out), 0);
    step();
    checkOutput("col0_elem1", int'(d_out), 8);
    wait_drain();

    $display("[TB] three back-to-back blocks");
    for (int b = 0; b < 3; b++) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) row[c*W +: W] = W'(100*b + 8*r + c);
        applyStimulus(row);
        if (b == 0 && r == 0) first_start = row_start_cycle;
      end
    end
    checkOutput("stream_span", row_start_cycle - first_start, 184);
    wait_drain();

    $display("[TB] both banks full with rdy_in low");
    rdy_in = 1'b0;
    send_block(300, 1'b0);
    send_block(400, 1'b0);
    checkOutput("both_full_rdy_out", int'(rdy_out), 0);
    ena_in = 1'b1;
    d_in = 12'h5A5;
    repeat (10) step();
    ena_in = 1'b0;
    rdy_in = 1'b1;
    #1;
    checkOutput("drain_ena_out", int'(ena_out), 1);
    repeat (63) step();
    checkOutput("rdy_out_before_free", int'(rdy_out), 0);
    step();
    checkOutput("rdy_out_after_free", int'(rdy_out), 1);
    wait_drain();

    $display("[TB] ena_in held high with random data");
    for (int k = 0; k < 128; k++) begin
      ena_in = 1'b1;
      d_in = W'($urandom);
      step();
    end
    ena_in = 1'b0;
    wait_drain();

    $display("[TB] signed extremes");
    send_block(0, 1'b1);
    checkOutput("ext_elem0", int'(d_out), 'h800);
    step();
    checkOutput("ext_elem1", int'(d_out), 'h7FF);
    wait_drain();

    $display("[TB] reset in the middle of a block");
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 8; c++) row[c*W +: W] = W'(500 + 8*r + c);
      applyStimulus(row);
    end
    ena_in = 1'b1;
    d_in = W'(516);
    step();
    ena_in = 1'b0;
    for (int k = 17; k < 20; k++) begin
      d_in = W'(500 + k);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checkOutput("post_rst_rdy_out", int'(rdy_out), 1);
    checkOutput("post_rst_ena_out", int'(ena_out), 0);
    repeat (3) step();
    checkOutput("post_rst_ena_idle", int'(ena_out), 0);
    send_block(600, 1'b0);
    checkOutput("fresh_elem0", int'(d_out), 600);
    wait_drain();

    checkOutput("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dct_transpose.md
Name: dct_transpose

Overview:
- Double-banked 8x8 transpose buffer between the row-pass 1-D DCT (STAGE=0, 12-bit output) and the column-pass 1-D DCT (STAGE=1, 12-bit input).
- Accepts 8 row bursts of 8 coefficients (row-major) and emits 8 column bursts of 8 coefficients (column-major).
- Two banks let one block be written while the previous block is read.

Parameters:
W  12  coefficient width in bits; two's-complement data passed bit-exact.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ena_in  in  1  upstream burst start; qualifies element 0 of an input row
rdy_out  out  1  buffer can accept a row burst this cycle
d_in  in  W  input coefficient
ena_out  out  1  downstream burst start; marks element 0 of an output column
rdy_in  in  1  downstream can accept a column burst this cycle
d_out  out  W  output coefficient

Behaviour:
- Burst protocol, both sides:
  - A burst starts on a cycle where the receiver's rdy and the sender's ena are both 1.
  - That cycle carries element 0. Elements 1..7 follow on the next 7 consecutive cycles unconditionally.
  - ena is ignored on every other cycle.
- Storage: mem[2][8][8] x W. No reset of mem contents.
- Write-side state:
  - wr_sel (1b), wr_row (3b), wr_col (3b), wr_active.
  - full[1:0] flags, shared with the read side.
- Write-side behaviour:
  - rdy_out = !rst && !full[wr_sel] && !wr_active (combinational).
  - Burst start: mem[wr_sel][wr_row][0] <= d_in; wr_active <= 1; wr_col <= 1.
  - While active: mem[wr_sel][wr_row][wr_col] <= d_in; wr_col++.
  - On wr_col == 7: wr_active <= 0; wr_row++.
  - If wr_row was 7: full[wr_sel] <= 1 and wr_sel toggles.
  - Gaps between row bursts are allowed.
- Read-side state: rd_sel, rd_col, rd_row, rd_active.
- Read-side behaviour:
  - ena_out = full[rd_sel] && !rd_active && rdy_in && !rst (combinational).
  - d_out = mem[rd_sel][rd_row][rd_col] during a burst, including the ena_out cycle (rd_row = 0 then); d_out = 0 otherwise.
  - Burst start: rd_active <= 1; rd_row <= 1.
  - While active: rd_row++. On rd_row == 7: rd_active <= 0; rd_col++.
  - If rd_col was 7: full[rd_sel] <= 0 and rd_sel toggles.
  - Gaps between column bursts occur while rdy_in = 0.
- Simultaneous events:
  - Write only targets a non-full bank; read only targets a full bank. Same-bank collision is impossible by construction.
  - A full flag set and a full flag cleared in the same cycle act on different banks; both take effect.
  - A bank freed on the last read element is writable the next cycle.
- Latency and throughput:
  - Last input element of a block at cycle t gives earliest ena_out at t+1 (read side idle, rdy_in = 1).
  - Sustained rate is 64 cycles per block per side, with zero input bubbles when rdy_in is held high.
- Full condition: both banks full gives rdy_out = 0 until the current read block completes.
- Reset: rst clears wr_sel, rd_sel, all counters, the active flags and full.
  - Outputs during and after reset: ena_out = 0, rdy_out = 0 while rst is high, d_out = 0.
  - A reset mid-burst aborts both sides; partially written data is discarded and is never emitted.

Test Plan:
- Reset, then one block with d_in = 8r+c streamed back-to-back, rdy_in = 1 -> 8 ena_out pulses. Column 0 is 0,8,...,56 and column 7 is 7,15,...,63; first ena_out on the cycle after input element 63.
- Three consecutive blocks (offsets 0, 100, 200), ena_in raised whenever rdy_out = 1, rdy_in = 1 -> rdy_out never low at a row boundary and 192 input cycles complete with no gaps. Outputs are the transposes in order.
- rdy_in = 0 while two blocks are written -> rdy_out = 0 after the second block and a third ena_in is ignored. Then raise rdy_in -> the first block drains and rdy_out returns 1 the cycle after its last output element.
- ena_in held high every cycle and d_in random -> only every 8th cycle (when rdy_out = 1) starts a row, and the output is the exact transpose.
- Signed extremes: a block of alternating -2048 (0x800) and 2047 (0x7FF) -> emitted bit-exact at transposed positions.
- After 20 input elements, rst pulsed for 1 cycle -> ena_out stays 0 and rdy_out = 1 the cycle after rst falls. A fresh block outputs correctly with no stale values.
